// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 cursor controller.
//  - Set-2 scan codes that the decoder acts on.
//  - 2-bit encoding of the prefix-decoder state.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_cursor_ctrl_prefix_timeout.sv
// prefix_timeout: cycle counter that bounds how long the decoder may sit in a
// prefix state.
//  clk, rst  clock and async active-high reset
//  clr       synchronous clear (has priority over en)
//  en        count one cycle
//  expired   high while the count equals TIMEOUT_CYC-1
module prefix_timeout #(
    parameter int TIMEOUT_CYC = 8200000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            // Saturate so the counter can never wrap back into range.
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/ps2_cursor_ctrl.sv
// ps2_cursor_ctrl: decodes PS/2 set-2 bytes into cursor moves over a
// GRID_W x GRID_H grid plus a one-cycle select pulse.
//  CLK82MHZ    system clock, rising edge
//  RESET       async active-high reset
//  scan_code   received byte, valid while scan_valid=1
//  scan_valid  one-cycle strobe per byte
//  coordx      cursor column 0..GRID_W-1 (registered)
//  coordy      cursor row 0..GRID_H-1 (registered)
//  enter       one-cycle select pulse (registered)
module ps2_cursor_ctrl
    import ps2_pkg::*;
#(
    parameter int GRID_W      = 6,
    parameter int GRID_H      = 4,
    parameter int TIMEOUT_CYC = 8200000
) (
    input  logic       CLK82MHZ,
    input  logic       RESET,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [2:0] coordx,
    output logic [1:0] coordy,
    output logic       enter
);

    localparam logic [2:0] X_MAX = 3'(GRID_W - 1);
    localparam logic [1:0] Y_MAX = 2'(GRID_H - 1);

    ps2_state_e state;
    logic       tmo_expired;

    // The counter only runs while a prefix is pending; any byte restarts it.
    prefix_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_prefix_timeout (
        .clk    (CLK82MHZ),
        .rst    (RESET),
        .clr    (scan_valid || state == ST_IDLE),
        .en     (state != ST_IDLE),
        .expired(tmo_expired)
    );

    always_ff @(posedge CLK82MHZ or posedge RESET) begin
        if (RESET) begin
            state  <= ST_IDLE;
            coordx <= '0;
            coordy <= '0;
            enter  <= 1'b0;
        end else begin
            enter <= 1'b0;
            if (scan_valid) begin
                // A byte arriving on the expiry cycle is still decoded in
                // the current state, so this branch is checked first.
                unique case (state)
                    ST_IDLE: begin
                        if (scan_code == SC_BREAK)      state <= ST_BRK;
                        else if (scan_code == SC_EXT)   state <= ST_EXT;
                        else if (scan_code == SC_ENTER) enter <= 1'b1;
                    end
                    ST_BRK: state <= ST_IDLE;
                    ST_EXT: begin
                        state <= ST_IDLE;
                        unique case (scan_code)
                            SC_BREAK: state  <= ST_EXT_BRK;
                            SC_UP:    coordy <= (coordy == 2'd0)  ? Y_MAX : coordy - 2'd1;
                            SC_DOWN:  coordy <= (coordy == Y_MAX) ? 2'd0  : coordy + 2'd1;
                            SC_LEFT:  coordx <= (coordx == 3'd0)  ? X_MAX : coordx - 3'd1;
                            SC_RIGHT: coordx <= (coordx == X_MAX) ? 3'd0  : coordx + 3'd1;
                            SC_ENTER: enter  <= 1'b1;
                            default:  ;
                        endcase
                    end
                    ST_EXT_BRK: state <= ST_IDLE;
                    default:    state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE && tmo_expired) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_cursor_ctrl.sv
// Directed bench for ps2_cursor_ctrl with a short prefix timeout.
module tb_ps2_cursor_ctrl;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [2:0] coordx;
    logic [1:0] coordy;
    logic       enter;

    int n_run  = 0;
    int n_fail = 0;
    int n_enter = 0;

    always #5 clk = ~clk;

    ps2_cursor_ctrl #(
        .GRID_W(6), .GRID_H(4), .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK82MHZ  (clk),
        .RESET     (rst),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .coordx    (coordx),
        .coordy    (coordy),
        .enter     (enter)
    );

    always @(posedge clk) if (enter) n_enter++;

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One byte per call; consecutive calls give back-to-back strobes.
    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rst = 1'b1; scan_code = 8'h00; scan_valid = 1'b0;
        idle(3);
        chk("rst_x", coordx, 0);
        chk("rst_y", coordy, 0);
        chk("rst_enter", enter, 0);
        rst = 1'b0;
        idle(20);
        chk("idle_x", coordx, 0);
        chk("idle_y", coordy, 0);
        chk("idle_enter", n_enter, 0);

        // Right five times, then wrap.
        for (int i = 1; i <= 6; i++) begin
            send(8'hE0); send(8'h74);
            chk($sformatf("right_%0d", i), coordx, i % 6);
        end
        chk("right_y", coordy, 0);

        // Up wraps; extended release does nothing and leaves decoder idle.
        send(8'hE0); send(8'h75);
        chk("up_wrap", coordy, 3);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("rel_y", coordy, 3);
        chk("rel_x", coordx, 0);
        send(8'hE0); send(8'h74);
        chk("after_rel_x", coordx, 1);
        send(8'hE0); send(8'h72);
        chk("down_wrap", coordy, 0);
        send(8'hE0); send(8'h6B);
        chk("left_1", coordx, 0);
        send(8'hE0); send(8'h6B);
        chk("left_wrap", coordx, 5);
        send(8'h74);
        chk("bare_right_ignored", coordx, 5);

        // Enter pulses: make, break, extended make.
        base = n_enter;
        send(8'h5A);
        chk("enter_make", enter, 1);
        idle(1);
        chk("enter_one_cycle", enter, 0);
        send(8'hF0);
        chk("enter_brk_f0", enter, 0);
        send(8'h5A);
        chk("enter_brk", enter, 0);
        send(8'hE0); send(8'h5A);
        chk("enter_ext", enter, 1);
        idle(1);
        chk("enter_ext_off", enter, 0);
        idle(2);
        chk("enter_count", n_enter - base, 2);

        // Timeout: prefix abandoned after TMO idle cycles.
        send(8'hE0);
        idle(TMO);
        send(8'h74);
        chk("tmo_expired", coordx, 5);
        // Byte on the expiry cycle still decodes.
        send(8'hE0);
        idle(TMO - 1);
        send(8'h74);
        chk("tmo_edge", coordx, 0);

        // Reset mid-sequence drops the prefix.
        send(8'hE0);
        rst = 1'b1; #3; rst = 1'b0;
        idle(1);
        chk("rst_mid_x", coordx, 0);
        chk("rst_mid_y", coordy, 0);
        send(8'h72);
        chk("rst_mid_72", coordy, 0);
        send(8'hE0); send(8'h72);
        chk("rst_then_down", coordy, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
